// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with E0/F0 prefix decoding and a held-key bitmap for the game controls.
// Everything runs on the system clock; the PS/2 pins are synchronised, filtered and edge-detected.
module ps2_key_tracker #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       kb_clock,
    input  logic       kb_data,
    output logic [4:0] keys_held,
    output logic       key_event,
    output logic [8:0] event_code,
    output logic       event_break,
    output logic       frame_error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, RECV} frame_state_t;
    typedef enum logic [1:0] {D_BASE, D_EXT, D_BRK, D_EXTBRK} dec_state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt, r_filt_d;
    logic [FW-1:0] r_filt_cnt;
    logic          w_strobe;

    frame_state_t  r_state, w_state_nx;
    logic [3:0]    r_bitcnt, w_bitcnt_nx;
    logic [7:0]    r_shift, w_shift_nx;
    logic          r_par, w_par_nx;
    logic [TW-1:0] r_to_cnt, w_to_nx;
    logic          w_ferr, w_good;
    logic          r_byte_valid, r_frame_error;

    dec_state_t    r_dstate, w_dstate_nx;
    logic          w_ev, w_ev_ext, w_ev_brk;
    logic          r_key_event, r_event_break;
    logic [8:0]    r_event_code;
    logic [4:0]    r_keys_held;
    logic [4:0]    w_key_mask;

    // Pins idle high, so the synchronisers and filter start at 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_s1 <= kb_clock;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= kb_data;
            r_dat_s2 <= r_dat_s1;
            r_filt_d <= r_filt;
            if (r_clk_s2 == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt     <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_strobe = r_filt_d & ~r_filt;

    always_comb begin
        w_state_nx  = r_state;
        w_bitcnt_nx = r_bitcnt;
        w_shift_nx  = r_shift;
        w_par_nx    = r_par;
        w_to_nx     = '0;
        w_ferr      = 1'b0;
        w_good      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_strobe) begin
                    if (!r_dat_s2) begin
                        w_state_nx  = RECV;
                        w_bitcnt_nx = 4'd1;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
            end
            RECV: begin
                if (w_strobe) begin
                    if (r_bitcnt <= 4'd8) begin
                        w_shift_nx  = {r_dat_s2, r_shift[7:1]};
                        w_bitcnt_nx = r_bitcnt + 4'd1;
                    end else if (r_bitcnt == 4'd9) begin
                        w_par_nx    = r_dat_s2;
                        w_bitcnt_nx = 4'd10;
                    end else begin
                        w_state_nx  = IDLE;
                        w_bitcnt_nx = 4'd0;
                        // Odd parity over data plus parity bit, and a high stop bit.
                        if ((^{r_shift, r_par}) && r_dat_s2) w_good = 1'b1;
                        else                                 w_ferr = 1'b1;
                    end
                end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nx  = IDLE;
                    w_bitcnt_nx = 4'd0;
                    w_ferr      = 1'b1;
                end else begin
                    w_to_nx = r_to_cnt + 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bitcnt      <= 4'd0;
            r_shift       <= 8'd0;
            r_par         <= 1'b0;
            r_to_cnt      <= '0;
            r_byte_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_bitcnt      <= w_bitcnt_nx;
            r_shift       <= w_shift_nx;
            r_par         <= w_par_nx;
            r_to_cnt      <= w_to_nx;
            r_byte_valid  <= w_good;
            r_frame_error <= w_ferr;
        end
    end

    // r_shift stays stable until the next frame's first data bit, so it is the received byte here.
    always_comb begin
        w_dstate_nx = r_dstate;
        w_ev        = 1'b0;
        w_ev_ext    = 1'b0;
        w_ev_brk    = 1'b0;
        if (r_byte_valid) begin
            case (r_dstate)
                D_BASE: begin
                    if (r_shift == 8'hE0)      w_dstate_nx = D_EXT;
                    else if (r_shift == 8'hF0) w_dstate_nx = D_BRK;
                    else                       w_ev = 1'b1;
                end
                D_EXT: begin
                    if (r_shift == 8'hF0)      w_dstate_nx = D_EXTBRK;
                    else if (r_shift != 8'hE0) begin
                        w_ev        = 1'b1;
                        w_ev_ext    = 1'b1;
                        w_dstate_nx = D_BASE;
                    end
                end
                D_BRK, D_EXTBRK: begin
                    w_dstate_nx = D_BASE;
                    if (r_shift != 8'hE0 && r_shift != 8'hF0) begin
                        w_ev     = 1'b1;
                        w_ev_brk = 1'b1;
                        w_ev_ext = (r_dstate == D_EXTBRK);
                    end
                end
                default: w_dstate_nx = D_BASE;
            endcase
        end
    end

    always_comb begin
        w_key_mask = 5'b00000;
        case ({w_ev_ext, r_shift})
            9'h175:  w_key_mask = 5'b00001;
            9'h172:  w_key_mask = 5'b00010;
            9'h16B:  w_key_mask = 5'b00100;
            9'h174:  w_key_mask = 5'b01000;
            9'h01B:  w_key_mask = 5'b10000;
            default: w_key_mask = 5'b00000;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dstate      <= D_BASE;
            r_key_event   <= 1'b0;
            r_event_code  <= 9'd0;
            r_event_break <= 1'b0;
            r_keys_held   <= 5'd0;
        end else begin
            r_dstate    <= w_dstate_nx;
            r_key_event <= w_ev;
            if (w_ev) begin
                r_event_code  <= {w_ev_ext, r_shift};
                r_event_break <= w_ev_brk;
                if (w_ev_brk) r_keys_held <= r_keys_held & ~w_key_mask;
                else          r_keys_held <= r_keys_held | w_key_mask;
            end
        end
    end

    assign keys_held   = r_keys_held;
    assign key_event   = r_key_event;
    assign event_code  = r_event_code;
    assign event_break = r_event_break;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: drives PS/2 frames on the pins, queues expected events and
// compares them as key_event pulses appear; each scenario task checks keys_held and error counts.
module tb_ps2_key_tracker;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 400;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       kb_clock = 1'b1;
    logic       kb_data = 1'b1;
    logic [4:0] keys_held;
    logic       key_event;
    logic [8:0] event_code;
    logic       event_break;
    logic       frame_error;

    logic [9:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         ferr_cnt = 0;

    ps2_key_tracker #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clock(clock), .reset(reset), .kb_clock(kb_clock), .kb_data(kb_data),
        .keys_held(keys_held), .key_event(key_event), .event_code(event_code),
        .event_break(event_break), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    // scoreboard: every key_event is matched against the oldest queued {break, ext, code}
    always @(negedge clock) begin
        if (frame_error) ferr_cnt++;
        if (key_event) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event got=%h required=none", {event_break, event_code});
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({event_break, event_code} !== e) begin
                    n_err++;
                    $display("FAIL event got=%h required=%h", {event_break, event_code}, e);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        kb_data = b;
        wait_cyc(5);
        kb_clock = 1'b0;
        wait_cyc(15);
        kb_clock = 1'b1;
        wait_cyc(10);
    endtask

    // Sends the first nbits of a frame; glitch_at inserts a short low pulse before that bit.
    task automatic send_frame(input logic [7:0] b, input logic flip_par, input int nbits, input int glitch_at);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_at) begin
                kb_clock = 1'b0;
                wait_cyc(FILTER_LEN - 1);
                kb_clock = 1'b1;
                wait_cyc(10);
            end
            send_bit(fr[i]);
        end
        wait_cyc(20);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11, -1);
    endtask

    task automatic expect_ev(input logic brk, input logic [8:0] code);
        exp_q.push_back({brk, code});
    endtask

    task automatic check_keys(input string name, input logic [4:0] exp);
        n_vec++;
        if (keys_held !== exp) begin
            n_err++;
            $display("FAIL %s keys_held got=%b required=%b", name, keys_held, exp);
        end
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s missing_events got=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_ferr(input string name, input int exp);
        n_vec++;
        if (ferr_cnt !== exp) begin
            n_err++;
            $display("FAIL %s frame_errors got=%0d required=%0d", name, ferr_cnt, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_vec++;
        if ({keys_held, key_event, event_code, event_break, frame_error} !== 17'd0) begin
            n_err++;
            $display("FAIL %s outputs got=%b_%b_%h_%b_%b required=all_zero", name,
                     keys_held, key_event, event_code, event_break, frame_error);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(5);
        check_outputs_zero("reset");
        reset = 1'b0;
        wait_cyc(10);
        check_ferr("reset_ferr", 0);
    endtask

    task automatic test_make_break();
        expect_ev(1'b0, 9'h01B);
        send_byte(8'h1B);
        check_keys("shoot_make", 5'b10000);
        send_byte(8'hF0);
        expect_ev(1'b1, 9'h01B);
        send_byte(8'h1B);
        check_keys("shoot_break", 5'b00000);
        check_drained("make_break");
    endtask

    task automatic test_extended();
        send_byte(8'hE0);
        expect_ev(1'b0, 9'h175);
        send_byte(8'h75);
        check_keys("up_make", 5'b00001);
        send_byte(8'hE0);
        expect_ev(1'b0, 9'h16B);
        send_byte(8'h6B);
        check_keys("left_make", 5'b00101);
        send_byte(8'hE0);
        send_byte(8'hF0);
        expect_ev(1'b1, 9'h175);
        send_byte(8'h75);
        check_keys("up_break", 5'b00100);
        check_drained("extended");
    endtask

    task automatic test_parity();
        int f0;
        f0 = ferr_cnt;
        send_frame(8'h1B, 1'b1, 11, -1);
        check_ferr("parity", f0 + 1);
        check_keys("parity_keys", 5'b00100);
        check_drained("parity");
    endtask

    task automatic test_timeout();
        int f0;
        f0 = ferr_cnt;
        send_frame(8'h1C, 1'b0, 5, -1);
        wait_cyc(TIMEOUT_CYCLES + 100);
        check_ferr("timeout", f0 + 1);
        expect_ev(1'b0, 9'h01C);
        send_byte(8'h1C);
        check_keys("timeout_keys", 5'b00100);
        check_ferr("timeout_after", f0 + 1);
        check_drained("timeout");
    endtask

    task automatic test_glitch();
        int f0;
        f0 = ferr_cnt;
        send_byte(8'hE0);
        expect_ev(1'b0, 9'h174);
        send_frame(8'h74, 1'b0, 11, 4);
        check_keys("glitch_keys", 5'b01100);
        check_ferr("glitch_ferr", f0);
        check_drained("glitch");
    endtask

    task automatic test_back_to_back();
        expect_ev(1'b0, 9'h01B);
        send_byte(8'h1B);
        check_keys("b2b_shoot", 5'b11100);
        expect_ev(1'b0, 9'h01B);
        send_byte(8'h1B);
        check_keys("b2b_repeat", 5'b11100);
        expect_ev(1'b0, 9'h005);
        send_byte(8'h05);
        check_keys("b2b_unmapped", 5'b11100);
        send_byte(8'hF0);
        expect_ev(1'b1, 9'h01B);
        send_byte(8'h1B);
        send_byte(8'hE0);
        send_byte(8'hF0);
        expect_ev(1'b1, 9'h174);
        send_byte(8'h74);
        check_keys("b2b_release", 5'b00100);
        send_byte(8'hF0);
        send_byte(8'hE0);
        expect_ev(1'b0, 9'h072);
        send_byte(8'h72);
        check_keys("b2b_prefix_abort", 5'b00100);
        check_drained("back_to_back");
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hE0);
        send_frame(8'h74, 1'b0, 4, -1);
        @(negedge clock);
        reset = 1'b1;
        wait_cyc(3);
        check_outputs_zero("mid_reset");
        reset = 1'b0;
        kb_data = 1'b1;
        wait_cyc(10);
        expect_ev(1'b0, 9'h074);
        send_byte(8'h74);
        check_keys("mid_reset_keys", 5'b00000);
        check_drained("mid_reset");
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_parity();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
